eth_rx_ctrl: RTL

- Receive-side controller that sits after the MAC/IP/UDP receive stack and its payload FIFO.
- Sequences the stack's fs/fd frame handshake and filters each frame on destination IP and port.
- Drains accepted payload bytes from the FIFO into a downstream byte stream with valid/ready backpressure; flushes rejected or stalled frames so the FIFO never holds stale bytes.
- Keeps accepted and dropped frame counters.

---
 rtl/eth_rx_ctrl_if.sv | 11 +
 rtl/eth_rx_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ctrl_if.sv
// rtl/eth_rx_ctrl_if.sv - downstream payload byte stream of eth_rx_ctrl
interface eth_rx_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       m_abort;

  modport master (output m_data, m_valid, m_last, m_abort, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_abort, output m_ready);
endinterface

// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - UDP receive frame filter and payload drain (option macro: RX_BCAST_EN)
module eth_rx_ctrl #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_fs,
  output logic             rx_fd,
  input  logic [31:0]      det_ip_addr,
  input  logic [31:0]      src_ip_addr,
  input  logic [15:0]      det_ip_port,
  input  logic [15:0]      src_ip_port,
  input  logic [15:0]      data_len,
  output logic             fifo_rxen,
  input  logic [7:0]       fifo_rxd,
  input  logic [31:0]      local_ip,
  input  logic [15:0]      local_port,
  eth_rx_ctrl_if.master    m,
  output logic [31:0]      m_src_ip,
  output logic [15:0]      m_src_port,
  output logic [15:0]      m_len,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int ST_W = $clog2(TIMEOUT + 1);

  logic [2:0]      state;
  logic [15:0]     remaining;
  logic [7:0]      bd0, bd1;
  logic            bl0, bl1;
  logic [1:0]      bcnt;
  logic            rd_pend, rd_last;
  logic [ST_W-1:0] stall_cnt;
  logic            ip_hit, accept, pop, stall, abort, push;
  logic [2:0]      occ;
  logic [7:0]      nd0, nd1;
  logic            nl0, nl1;
  logic [1:0]      ncnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef RX_BCAST_EN
  assign ip_hit = (det_ip_addr == local_ip) || (det_ip_addr == 32'hFFFF_FFFF);
`else
  assign ip_hit = (det_ip_addr == local_ip);
`endif
  assign accept = ip_hit && (det_ip_port == local_port);

  assign m.m_valid = (state == S_READ) && (bcnt != 2'd0);
  assign m.m_data  = bd0;
  assign m.m_last  = m.m_valid && bl0;
  assign rx_fd     = (state == S_DONE);
  assign pop       = m.m_valid && m.m_ready;
  assign stall     = m.m_valid && !m.m_ready;
  assign abort     = stall && (stall_cnt == ST_W'(TIMEOUT - 1));
  assign push      = rd_pend && (state == S_READ);
  // slots committed after this cycle's pop; in-flight reads already own a slot
  assign occ       = {1'b0, bcnt} + {2'b0, rd_pend} - {2'b0, pop};

  // FIFO read strobe: throttled by skid space in READ, free-running flush in DROP
  always_comb begin
    fifo_rxen = 1'b0;
    case (state)
      S_READ:  fifo_rxen = (remaining != 16'd0) && (occ < 3'd2);
      S_DROP:  fifo_rxen = (remaining != 16'd0);
      default: fifo_rxen = 1'b0;
    endcase
  end

  // next skid-buffer contents: shift out on pop, then append returning byte
  always_comb begin
    nd0  = bd0;
    nd1  = bd1;
    nl0  = bl0;
    nl1  = bl1;
    ncnt = bcnt;
    if (pop) begin
      nd0  = bd1;
      nl0  = bl1;
      ncnt = bcnt - 2'd1;
    end
    if (push) begin
      if (ncnt == 2'd0) begin
        nd0 = fifo_rxd;
        nl0 = rd_last;
      end else begin
        nd1 = fifo_rxd;
        nl1 = rd_last;
      end
      ncnt = ncnt + 2'd1;
    end
  end

  // frame sequencing, buffering, timeout and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      bd0        <= '0;
      bd1        <= '0;
      bl0        <= 1'b0;
      bl1        <= 1'b0;
      bcnt       <= '0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
      stall_cnt  <= '0;
      m.m_abort  <= 1'b0;
      m_src_ip   <= '0;
      m_src_port <= '0;
      m_len      <= '0;
      cnt_ok     <= '0;
      cnt_drop   <= '0;
    end else begin
      m.m_abort <= 1'b0;
      if (fifo_rxen) remaining <= remaining - 16'd1;
      rd_pend <= (state == S_READ) && fifo_rxen && !abort;
      rd_last <= (remaining == 16'd1);
      case (state)
        S_IDLE: begin
          if (rx_fs) begin
            m_src_ip   <= src_ip_addr;
            m_src_port <= src_ip_port;
            m_len      <= data_len;
            remaining  <= data_len;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (remaining == 16'd0) begin
              cnt_ok <= sat_inc(cnt_ok);
              state  <= S_DONE;
            end else begin
              state  <= S_READ;
            end
          end else begin
            cnt_drop <= sat_inc(cnt_drop);
            state    <= (remaining == 16'd0) ? S_DONE : S_DROP;
          end
        end
        S_READ: begin
          bd0  <= nd0;
          bd1  <= nd1;
          bl0  <= nl0;
          bl1  <= nl1;
          bcnt <= ncnt;
          if (pop) stall_cnt <= '0;
          else if (stall) stall_cnt <= stall_cnt + ST_W'(1);
          if (abort) begin
            m.m_abort <= 1'b1;
            bcnt      <= '0;
            stall_cnt <= '0;
            cnt_drop  <= sat_inc(cnt_drop);
            state     <= S_DROP;
          end else if (pop && bl0) begin
            bcnt      <= '0;
            stall_cnt <= '0;
            cnt_ok    <= sat_inc(cnt_ok);
            state     <= S_DONE;
          end
        end
        S_DROP: begin
          // remaining hit zero last cycle, so the final read returns now
          if (remaining == 16'd0) state <= S_DONE;
        end
        S_DONE: begin
          if (!rx_fs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
